// File: rtl/fpu_pkg.sv
// Shared types and width helpers for the FPU normalizer.
package fpu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        PK_NONE,
        PK_NORM,
        PK_ZERO,
        PK_UNDER,
        PK_CLAMP
    } pack_t;

    localparam int EXP_MIN_NORM = 1;

    function automatic int exp_max(input int e);
        return (1 << e) - 1;
    endfunction

    function automatic int mant_width(input int s);
        return 2 * (s + 1);
    endfunction

    function automatic int lz_width(input int m);
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/fpu_lzc.sv
// Combinational leading-zero counter; count is WIDTH when the input is zero.
module fpu_lzc #(
    parameter int WIDTH = 105,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] data_i,
    output logic [CNT_W-1:0] count_o,
    output logic             zero_o
);

    always_comb begin
        count_o = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (data_i[i]) begin
                count_o = CNT_W'(WIDTH - 1 - i);
            end
        end
    end

    assign zero_o = ~|data_i;

endmodule

// File: rtl/fpu_normalize.sv
// Multi-cycle leading-one normalizer ahead of the FPU rounder.
// Define FPU_NORMALIZE_SUBNORMAL_EN for gradual underflow; default flushes to zero.
module fpu_normalize
    import fpu_pkg::*;
#(
    parameter int EXPONENT_WIDTH    = 11,
    parameter int SIGNIFICAND_WIDTH = 52,
    parameter int SHIFT_STEP        = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic                                 in_sign,
    input  logic [EXPONENT_WIDTH+1:0]            in_exponent,
    input  logic [2*(SIGNIFICAND_WIDTH+1)-1:0]   in_mantissa,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic                                 out_sign,
    output logic [EXPONENT_WIDTH-1:0]            out_exponent,
    output logic [SIGNIFICAND_WIDTH:0]           out_significand,
    output logic                                 out_guard,
    output logic                                 out_round,
    output logic                                 out_sticky,
    output logic                                 out_zero,
    output logic                                 out_overflow,
    output logic                                 out_underflow
);

    localparam int E  = EXPONENT_WIDTH;
    localparam int S  = SIGNIFICAND_WIDTH;
    localparam int M  = mant_width(S);
    localparam int XW = E + 2;
    localparam int LW = lz_width(M);

    localparam logic signed [XW-1:0] ONE_X  = XW'(EXP_MIN_NORM);
    localparam logic signed [XW-1:0] TOP_X  = XW'(exp_max(E));
    localparam logic signed [XW-1:0] STEP_X = XW'(SHIFT_STEP);
    localparam logic [LW-1:0]        STEP_L = LW'(SHIFT_STEP);

    state_t                state_q, state_d;
    logic                  sign_q;
    logic signed [XW-1:0]  exp_q, exp_d;
    logic [M-1:0]          mant_q, mant_d;
    logic                  sticky_q, sticky_d;

    logic [LW-1:0]         lz;
    logic                  lz_none;

    pack_t                 pk;
    logic [M-1:0]          pk_m;
    logic signed [XW-1:0]  pk_e;
    logic                  pk_st;
    logic [S+3:0]          cut;

    logic [E-1:0]          rexp_q, rexp_d;
    logic [S:0]            rsig_q, rsig_d;
    logic [2:0]            rgrs_q, rgrs_d;
    logic [2:0]            rflg_q, rflg_d;

    logic signed [XW-1:0]  room, exp_l;
    logic [LW-1:0]         lim, sh_l, resid;
    logic [M-1:0]          mant_l;

`ifdef FPU_NORMALIZE_SUBNORMAL_EN
    logic [XW-1:0]         need;
    logic [LW-1:0]         sh_r;
    logic [M-1:0]          rmask;
`endif

    fpu_lzc #(
        .WIDTH(M - 1),
        .CNT_W(LW)
    ) u_lzc (
        .data_i (mant_q[M-2:0]),
        .count_o(lz),
        .zero_o (lz_none)
    );

    // {significand, guard, round, sticky} taken below the implied-bit position
    function automatic logic [S+3:0] slice(input logic [M-1:0] m,
                                           input logic st);
        return {m[M-2 -: S+1], m[M-S-3], m[M-S-4],
                st | (|m[M-S-5:0])};
    endfunction

    always_comb begin
        state_d  = state_q;
        exp_d    = exp_q;
        mant_d   = mant_q;
        sticky_d = sticky_q;
        pk       = PK_NONE;
        pk_m     = mant_q;
        pk_e     = exp_q;
        pk_st    = sticky_q;

        // left shift never takes the exponent below one
        room   = exp_q - ONE_X;
        lim    = ($signed(room) < STEP_X) ? LW'(room) : STEP_L;
        sh_l   = (lz < lim) ? lz : lim;
        resid  = lz - sh_l;
        exp_l  = exp_q - XW'(sh_l);
        mant_l = mant_q << sh_l;

`ifdef FPU_NORMALIZE_SUBNORMAL_EN
        need  = ONE_X - exp_q;
        sh_r  = (need < XW'(SHIFT_STEP)) ? LW'(need) : STEP_L;
        rmask = ~({M{1'b1}} << sh_r);
`endif

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    exp_d    = in_exponent;
                    mant_d   = in_mantissa;
                    sticky_d = 1'b0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (lz_none && !mant_q[M-1] && !sticky_q) begin
                    pk = PK_ZERO;
                end else if ($signed(exp_q) < $signed(ONE_X)) begin
`ifdef FPU_NORMALIZE_SUBNORMAL_EN
                    if (need > XW'(S + 3)) begin
                        pk = PK_CLAMP;
                    end else begin
                        mant_d   = mant_q >> sh_r;
                        sticky_d = sticky_q | (|(mant_q & rmask));
                        exp_d    = exp_q + XW'(sh_r);
                    end
`else
                    pk = PK_UNDER;
`endif
                end else if (mant_q[M-1]) begin
                    pk    = PK_NORM;
                    pk_m  = mant_q >> 1;
                    pk_e  = exp_q + ONE_X;
                    pk_st = sticky_q | mant_q[0];
                end else if (resid == '0) begin
                    pk   = PK_NORM;
                    pk_m = mant_l;
                    pk_e = exp_l;
                end else if (exp_l == ONE_X) begin
                    pk   = PK_UNDER;
                    pk_m = mant_l;
                    pk_e = exp_l;
                end else begin
                    mant_d = mant_l;
                    exp_d  = exp_l;
                end
                if (pk != PK_NONE) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rexp_d = rexp_q;
        rsig_d = rsig_q;
        rgrs_d = rgrs_q;
        rflg_d = rflg_q;
        cut    = slice(pk_m, pk_st);
        unique case (pk)
            PK_NORM: begin
                if ($signed(pk_e) >= TOP_X) begin
                    rexp_d = '1;
                    rsig_d = '0;
                    rgrs_d = '0;
                    rflg_d = 3'b010;
                end else begin
                    rexp_d           = pk_e[E-1:0];
                    {rsig_d, rgrs_d} = cut;
                    rflg_d           = 3'b000;
                end
            end
            PK_ZERO: begin
                rexp_d = '0;
                rsig_d = '0;
                rgrs_d = '0;
                rflg_d = 3'b100;
            end
            PK_UNDER: begin
`ifdef FPU_NORMALIZE_SUBNORMAL_EN
                rexp_d           = '0;
                {rsig_d, rgrs_d} = cut;
                rflg_d           = 3'b001;
`else
                rexp_d = '0;
                rsig_d = '0;
                rgrs_d = '0;
                rflg_d = 3'b101;
`endif
            end
            PK_CLAMP: begin
                rexp_d = '0;
                rsig_d = '0;
                rgrs_d = {2'b00, (|pk_m) | pk_st};
                rflg_d = 3'b001;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            mant_q   <= '0;
            sticky_q <= 1'b0;
            rexp_q   <= '0;
            rsig_q   <= '0;
            rgrs_q   <= '0;
            rflg_q   <= '0;
        end else begin
            state_q  <= state_d;
            exp_q    <= exp_d;
            mant_q   <= mant_d;
            sticky_q <= sticky_d;
            rexp_q   <= rexp_d;
            rsig_q   <= rsig_d;
            rgrs_q   <= rgrs_d;
            rflg_q   <= rflg_d;
            if (state_q == IDLE && in_valid) begin
                sign_q <= in_sign;
            end
        end
    end

    assign in_ready        = (state_q == IDLE);
    assign out_valid       = (state_q == DONE);
    assign out_sign        = sign_q;
    assign out_exponent    = rexp_q;
    assign out_significand = rsig_q;
    assign out_guard       = rgrs_q[2];
    assign out_round       = rgrs_q[1];
    assign out_sticky      = rgrs_q[0];
    assign out_zero        = rflg_q[2];
    assign out_overflow    = rflg_q[1];
    assign out_underflow   = rflg_q[0];

endmodule

// File: tb/tb_fpu_normalize.sv
// Self-checking bench for fpu_normalize: directed table, corner sequences,
// and random transactions against an arithmetic reference model.
module tb_fpu_normalize;

    localparam int E  = 11;
    localparam int S  = 52;
    localparam int M  = 106;
    localparam int XW = 13;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_sign = 1'b0;
    logic [XW-1:0] in_exponent = '0;
    logic [M-1:0]  in_mantissa = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_sign;
    logic [E-1:0]  out_exponent;
    logic [S:0]    out_significand;
    logic          out_guard, out_round, out_sticky;
    logic          out_zero, out_overflow, out_underflow;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fpu_normalize #(
        .EXPONENT_WIDTH(E),
        .SIGNIFICAND_WIDTH(S),
        .SHIFT_STEP(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_sign(in_sign),
        .in_exponent(in_exponent),
        .in_mantissa(in_mantissa),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sign(out_sign),
        .out_exponent(out_exponent),
        .out_significand(out_significand),
        .out_guard(out_guard),
        .out_round(out_round),
        .out_sticky(out_sticky),
        .out_zero(out_zero),
        .out_overflow(out_overflow),
        .out_underflow(out_underflow)
    );

    logic [70:0] dut_vec;
    assign dut_vec = {out_zero, out_overflow, out_underflow, out_sign,
                      out_exponent, out_significand,
                      out_guard, out_round, out_sticky};

    task automatic chk(input string nm, input string tag,
                       input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s/%s: got %h want %h", nm, tag, act, req);
        end
    endtask

    function automatic logic [70:0] mk(input logic z, input logic o,
                                       input logic u, input logic sg,
                                       input logic [10:0] ex,
                                       input logic [52:0] sig,
                                       input logic g, input logic r,
                                       input logic s);
        return {z, o, u, sg, ex, sig, g, r, s};
    endfunction

    function automatic logic [70:0] fields(input logic sg, input int e,
                                           input logic [105:0] m,
                                           input logic st,
                                           input logic under);
        logic [105:0] lo;
        lo = m & ((106'd1 << 50) - 106'd1);
        if (!under && e >= 2047)
            return mk(0, 1, 0, sg, 11'h7ff, '0, 0, 0, 0);
        return mk(0, 0, under, sg, under ? 11'd0 : 11'(e),
                  53'(m >> 52), m[51], m[50], st | (lo != '0));
    endfunction

    // Reference: value = m * 2^(e-104); place leading one at bit 104.
    function automatic logic [70:0] model(input logic sg, input int ex,
                                          input logic [105:0] mt,
                                          output int lat);
        logic [105:0] m;
        logic st;
        int e, p, d;
        m = mt; e = ex; st = 1'b0; lat = -1;
        if (m == '0) begin
            lat = 1;
            return mk(1, 0, 0, sg, '0, '0, 0, 0, 0);
        end
        if (e < 1) begin
`ifdef FPU_NORMALIZE_SUBNORMAL_EN
            if (1 - e > 55) return mk(0, 0, 1, sg, '0, '0, 0, 0, 1);
            st = ((m & ((106'd1 << (1 - e)) - 106'd1)) != '0);
            m = m >> (1 - e);
            e = 1;
`else
            return mk(1, 0, 1, sg, '0, '0, 0, 0, 0);
`endif
        end
        p = -1;
        for (int i = 0; i < 106; i++) if (m[i]) p = i;
        if (p == 105) begin
            st = st | m[0];
            if (ex >= 1) lat = 1;
            return fields(sg, e + 1, m >> 1, st, 1'b0);
        end
        d = 104 - p;
        if (e - d >= 1) begin
            if (ex >= 1) lat = (d + 3) / 4 < 1 ? 1 : (d + 3) / 4;
            return fields(sg, e - d, m << d, st, 1'b0);
        end
`ifdef FPU_NORMALIZE_SUBNORMAL_EN
        return fields(sg, 1, m << (e - 1), st, 1'b1);
`else
        return mk(1, 0, 1, sg, '0, '0, 0, 0, 0);
`endif
    endfunction

    task automatic run(input string nm, input logic sg, input int ex,
                       input logic [105:0] mt, input logic [70:0] want,
                       input int lat_want, input int hold);
        int lat;
        @(negedge clk);
        chk(nm, "in_ready", 128'(in_ready), 128'(1));
        in_valid = 1'b1;
        in_sign = sg;
        in_exponent = XW'(ex);
        in_mantissa = mt;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk(nm, "out_valid", 128'(out_valid), 128'(1));
        chk(nm, "result", 128'(dut_vec), 128'(want));
        if (lat_want > 0) chk(nm, "latency", 128'(lat), 128'(lat_want));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk(nm, "hold", 128'({out_valid, in_ready, dut_vec}),
                128'({1'b1, 1'b0, want}));
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk(nm, "retire", 128'({out_valid, in_ready}), 128'(2'b01));
    endtask

    typedef struct {
        string        name;
        logic         sg;
        int           ex;
        logic [105:0] mt;
        logic [70:0]  want;
        int           lat;
    } vec_t;

    vec_t tbl[5];

    initial begin
        logic [127:0] w;
        logic [105:0] m;
        logic [70:0]  want;
        int           ex, lat, t;

        tbl[0] = '{"t1_norm", 1'b0, 1023, 106'd1 << 104,
                   mk(0, 0, 0, 0, 11'd1023, 53'd1 << 52, 0, 0, 0), 1};
        tbl[1] = '{"t2_carry", 1'b0, 1023, (106'd1 << 105) | 106'd1,
                   mk(0, 0, 0, 0, 11'd1024, 53'd1 << 52, 0, 0, 1), 1};
        tbl[2] = '{"t3_lz10", 1'b1, 1023, 106'd1 << 94,
                   mk(0, 0, 0, 1, 11'd1013, 53'd1 << 52, 0, 0, 0), 3};
        tbl[3] = '{"t4_zero", 1'b1, 500, 106'd0,
                   mk(1, 0, 0, 1, 11'd0, 53'd0, 0, 0, 0), 1};
`ifdef FPU_NORMALIZE_SUBNORMAL_EN
        tbl[4] = '{"t5_under", 1'b0, 3, 106'd1 << 94,
                   mk(0, 0, 1, 0, 11'd0, 53'd1 << 44, 0, 0, 0), 0};
`else
        tbl[4] = '{"t5_under", 1'b0, 3, 106'd1 << 94,
                   mk(1, 0, 1, 0, 11'd0, 53'd0, 0, 0, 0), 0};
`endif

        #12;
        chk("reset", "handshake", 128'({in_ready, out_valid}), 128'(2'b10));
        chk("reset", "outputs", 128'(dut_vec), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++)
            run(tbl[i].name, tbl[i].sg, tbl[i].ex, tbl[i].mt,
                tbl[i].want, tbl[i].lat, 0);

        run("t6_ovf", 1'b0, 2046, 106'd1 << 105,
            mk(0, 1, 0, 0, 11'h7ff, 53'd0, 0, 0, 0), 1, 5);

        // Abort an in-flight shift with an asynchronous reset pulse.
        @(negedge clk);
        in_valid = 1'b1;
        in_exponent = XW'(1023);
        in_mantissa = 106'd1 << 60;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("abort", "shifting", 128'({out_valid, in_ready}), 128'(2'b00));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort", "async", 128'({out_valid, in_ready}), 128'(2'b01));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort", "idle", 128'({out_valid, in_ready, dut_vec}),
            128'({2'b01, 71'd0}));

        for (int n = 0; n < 300; n++) begin
            w = {$urandom, $urandom, $urandom, $urandom};
            m = w[105:0];
            t = int'($urandom_range(0, 105));
            m = m & ((106'd1 << (t + 1)) - 106'd1);
            m = m | (106'd1 << t);
            if ($urandom_range(0, 15) == 0) m = '0;
            case ($urandom_range(0, 9))
                0: ex = -int'($urandom_range(0, 70));
                1: ex = int'($urandom_range(1, 12));
                2: ex = int'($urandom_range(2030, 2100));
                default: ex = int'($urandom_range(1, 2046));
            endcase
            want = model(1'($urandom_range(0, 1)), ex, m, lat);
            run("random", want[67], ex, m, want, lat,
                int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
